id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
Pipeline register between decode and execute. It accepts a decoded micro-op from ID over a valid/ready handshake and buffers it in a 2-entry skid buffer. It presents the selected ALU operands (op_a, op_b) and the ALU op code directly to the EX-stage ALU op units. It also supports pipeline flush (branch or exception) and carries a saturating back-pressure stall counter.

Parameters:
XLEN, 32, data path width
REG_ADDR_W, 5, register index width
ALU_OP_W, 4, ALU op code width (encoding from riscv_pkg::alu_op_e)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush: discard all buffered and incoming ops
in_valid  input  1  ID presents an op
in_ready  output  1  register can accept
in_pc  input  XLEN  instruction PC
in_rs1  input  XLEN  rs1 data
in_rs2  input  XLEN  rs2 data
in_imm  input  XLEN  sign-extended immediate
in_rd  input  REG_ADDR_W  destination register
in_alu_op  input  ALU_OP_W  ALU operation
in_alu_src  input  1  1 = op_b uses imm, 0 = op_b uses rs2
in_reg_write  input  1  writeback enable
out_valid  output  1  EX op valid
out_ready  input  1  EX consumes
op_a  output  XLEN  ALU operand a (rs1)
op_b  output  XLEN  ALU operand b (imm or rs2)
out_rs2  output  XLEN  store data pass-through
out_pc  output  XLEN  PC pass-through
out_rd  output  REG_ADDR_W  destination
out_alu_op  output  ALU_OP_W  ALU op
out_reg_write  output  1  writeback enable
stall_cnt  output  32  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, all payload outputs 0, stall_cnt=0, state EMPTY. Deassertion of reset is sampled on the next rising edge of clk.
- accept = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the rising edge.
- Latency: an op accepted at edge k is visible on the outputs with out_valid=1 after edge k, with no combinational in→out path.
- in_ready is registered and equals !(state==TWO). There is no combinational dependence on out_ready.
- op_b = alu_src ? imm : rs2. The alu_src select is stored and the mux is applied on the output side from the main entry.
- States:
  - EMPTY: main and skid entries both empty.
  - ONE: main entry valid.
  - TWO: main and skid entries both valid.
- Transitions:
  - EMPTY: accept→ONE with input loaded into main.
  - ONE: accept&!pop→TWO with input loaded into skid; accept&pop→ONE with input loaded into main; !accept&pop→EMPTY; otherwise hold.
  - TWO: pop→ONE with skid moved to main; otherwise hold. No accept is possible in TWO.
- Order is preserved, with no duplication or loss of ops.
- flush has highest priority. The next state is EMPTY, and any op accepted in the flush cycle is dropped. out_valid=0 and in_ready=1 after the edge. stall_cnt is unaffected.
- Whenever out_valid=0, all payload outputs (op_a, op_b, out_*) read 0 and out_reg_write=0. EX therefore sees a NOP bubble.
- stall_cnt increments when out_valid&!out_ready, and saturates at 32'hFFFF_FFFF with no wrap.
- Reset mid-operation clears everything immediately, regardless of the clock.

Decomposition:
- riscv_pkg holds:
  - alu_op_e: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - id_ex_payload_t: packed struct of pc, rs1, rs2, imm, rd, alu_op, alu_src, reg_write.
  - XLEN and REG_ADDR_W constants.
- One sub-module, pipe_skid_buf: a generic 2-entry valid/ready skid buffer parameterized by payload width.
- id_ex_reg instantiates pipe_skid_buf on id_ex_payload_t and adds the operand mux, the bubble zeroing and stall_cnt.

Test Plan:
- Reset then single op: rs1=32'hAAAA_AAAA, rs2=32'h5555_5555, alu_op=XOR, alu_src=0, out_ready=1 → one cycle later out_valid=1, op_a=AAAA_AAAA, op_b=5555_5555, out_alu_op=XOR; the next cycle out_valid=0 with all outputs 0.
- Immediate select: rs2=32'h1234, imm=32'hFFFF_FFF0, alu_src=1 → op_b=FFFF_FFF0.
- Back-pressure: out_ready=0 while 3 ops (pc=0x0,0x4,0x8) are offered → ops 0x0 and 0x4 are accepted, in_ready=0 after the second accept, and 0x8 is held. Raising out_ready then emits 0x0, 0x4, 0x8 in order, and stall_cnt equals the number of stalled cycles.
- Simultaneous accept and pop in ONE with continuous streaming of 100 ops at in_valid=out_ready=1 → throughput of 1 op/cycle, in_ready stays 1 and order is intact.
- Flush in TWO with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and none of the three ops ever appear.
- Async reset asserted mid-cycle while in state TWO → outputs zero immediately without a clock edge, and stall_cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types for the decode/execute boundary of the integer pipeline.
//   - XLEN / REG_ADDR_W / ALU_OP_W : data path, register index and op widths
//   - alu_op_e                     : ALU operation encoding
//   - id_ex_payload_t              : decoded micro-op carried from ID to EX
//   - skid_state_e                 : occupancy state of the 2-entry skid buffer
//   - sat_inc32 / sel_op_b         : small helpers used by id_ex_reg
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        alu_op_e               alu_op;
        logic                  alu_src;
        logic                  reg_write;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Counter increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // ALU operand b: immediate for I-type style ops, rs2 otherwise.
    function automatic logic [XLEN-1:0] sel_op_b(input logic            alu_src,
                                                  input logic [XLEN-1:0] imm,
                                                  input logic [XLEN-1:0] rs2);
        return alu_src ? imm : rs2;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry valid/ready skid buffer. Every output is driven straight
// from a flop, so there is no combinational path from in_* to out_* and
// in_ready does not depend on out_ready in the same cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush, drops stored and incoming data
//   in_valid   in   upstream presents data
//   in_ready   out  buffer can accept (registered, low only when full)
//   in_data    in   W-bit payload
//   out_valid  out  main entry holds data
//   out_ready  in   downstream consumes
//   out_data   out  W-bit payload from the main entry
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import riscv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  r_state;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_out_valid;
    logic         r_in_ready;

    logic w_accept;
    logic w_pop;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // State, storage and the handshake outputs are all updated together so
    // that out_valid/in_ready always agree with the occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SKID_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // Anything accepted in this same cycle is dropped as well.
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_pop) begin
                        // Downstream stalled: park the new op behind main.
                        r_skid     <= in_data;
                        r_state    <= SKID_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end else if (w_pop) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

endmodule

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// Decode-to-execute pipeline register. Decoded micro-ops are buffered in a
// 2-entry skid buffer; the EX side sees the selected ALU operands, the op
// code and the pass-through fields. While no op is valid every payload
// output reads zero so EX sees a NOP bubble. A saturating counter records
// the cycles in which a valid op was held back by EX.
//
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   flush                           drop all buffered and incoming ops
//   in_valid, in_ready              ID-side handshake
//   in_pc, in_rs1, in_rs2, in_imm   decoded operands and PC
//   in_rd, in_alu_op                destination register, ALU op
//   in_alu_src, in_reg_write        op_b select (1 = imm), writeback enable
//   out_valid, out_ready            EX-side handshake
//   op_a, op_b                      ALU operands (rs1, imm-or-rs2)
//   out_rs2, out_pc                 store data and PC pass-through
//   out_rd, out_alu_op              destination register, ALU op
//   out_reg_write                   writeback enable
//   stall_cnt                       saturating count of stalled-valid cycles
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
    parameter int ALU_OP_W   = riscv_pkg::ALU_OP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1,
    input  logic [XLEN-1:0]       in_rs2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    input  logic                  in_alu_src,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       op_a,
    output logic [XLEN-1:0]       op_b,
    output logic [XLEN-1:0]       out_rs2,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [ALU_OP_W-1:0]   out_alu_op,
    output logic                  out_reg_write,
    output logic [31:0]           stall_cnt
);

    import riscv_pkg::*;

    id_ex_payload_t        w_in_payload;
    id_ex_payload_t        w_main;
    logic                  w_out_valid;
    logic [ALU_OP_W-1:0]   w_main_alu_op;
    logic [31:0]           r_stall_cnt;

    assign w_in_payload = '{
        pc:        in_pc,
        rs1:       in_rs1,
        rs2:       in_rs2,
        imm:       in_imm,
        rd:        in_rd,
        alu_op:    alu_op_e'(in_alu_op),
        alu_src:   in_alu_src,
        reg_write: in_reg_write
    };

    pipe_skid_buf #(
        .W($bits(id_ex_payload_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_main)
    );

    assign w_main_alu_op = w_main.alu_op;

    // The operand mux sits after the register so the stored entry keeps both
    // rs2 (needed for stores) and imm. Stale entry contents are masked off
    // whenever the buffer is empty.
    assign out_valid     = w_out_valid;
    assign op_a          = w_out_valid ? w_main.rs1 : '0;
    assign op_b          = w_out_valid ? sel_op_b(w_main.alu_src, w_main.imm, w_main.rs2) : '0;
    assign out_rs2       = w_out_valid ? w_main.rs2 : '0;
    assign out_pc        = w_out_valid ? w_main.pc  : '0;
    assign out_rd        = w_out_valid ? w_main.rd  : '0;
    assign out_alu_op    = w_out_valid ? w_main_alu_op : '0;
    assign out_reg_write = w_out_valid & w_main.reg_write;

    // Counts EX back-pressure on a valid op; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [4:0]  in_rd;
    logic [3:0]  in_alu_op;
    logic        in_alu_src, in_reg_write;
    logic        out_valid, out_ready;
    logic [31:0] op_a, op_b, out_rs2, out_pc;
    logic [4:0]  out_rd;
    logic [3:0]  out_alu_op;
    logic        out_reg_write;
    logic [31:0] stall_cnt;

    id_ex_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_imm        (in_imm),
        .in_rd         (in_rd),
        .in_alu_op     (in_alu_op),
        .in_alu_src    (in_alu_src),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .out_rs2       (out_rs2),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_alu_op    (out_alu_op),
        .out_reg_write (out_reg_write),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered queue of at most two ops plus a stall count.
    op_t         q[$];
    op_t         cur;
    logic [31:0] m_stall;
    int          n_vec;
    int          n_err;
    int          n_ticks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        op_t e;
        bit  ev;
        ev = (q.size() > 0);
        e  = ev ? q[0] : '0;
        chk("out_valid",     32'(out_valid),     32'(ev));
        chk("in_ready",      32'(in_ready),      32'(q.size() < 2));
        chk("op_a",          op_a,               e.rs1);
        chk("op_b",          op_b,               e.alu_src ? e.imm : e.rs2);
        chk("out_rs2",       out_rs2,            e.rs2);
        chk("out_pc",        out_pc,             e.pc);
        chk("out_rd",        32'(out_rd),        32'(e.rd));
        chk("out_alu_op",    32'(out_alu_op),    32'(e.alu_op));
        chk("out_reg_write", 32'(out_reg_write), 32'(e.reg_write));
        chk("stall_cnt",     stall_cnt,          m_stall);
    endtask

    task automatic set_in(input op_t o);
        cur          = o;
        in_pc        = o.pc;
        in_rs1       = o.rs1;
        in_rs2       = o.rs2;
        in_imm       = o.imm;
        in_rd        = o.rd;
        in_alu_op    = o.alu_op;
        in_alu_src   = o.alu_src;
        in_reg_write = o.reg_write;
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.pc        = $urandom & 32'hFFFF_FFFC;
        o.rs1       = $urandom;
        o.rs2       = $urandom;
        o.imm       = $urandom;
        o.rd        = 5'($urandom);
        o.alu_op    = 4'($urandom_range(0, 9));
        o.alu_src   = 1'($urandom);
        o.reg_write = 1'($urandom);
        return o;
    endfunction

    // One clock: apply the model's view of the edge, then check at negedge.
    task automatic tick(output bit acc);
        bit a, p;
        @(posedge clk);
        n_ticks++;
        a = in_valid && (q.size() < 2);
        p = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (p) void'(q.pop_front());
            if (a) q.push_back(cur);
        end
        acc = a && !flush;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    // Offer one op until accepted; optionally raise out_ready after k tries.
    task automatic offer(input op_t o, input int raise_after);
        bit acc;
        int k;
        set_in(o);
        in_valid = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            if (k == raise_after) out_ready = 1'b1;
            tick(acc);
            k++;
        end
        chk("accept_bound", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        bit  acc;
        int  t0;

        n_vec = 0; n_err = 0; n_ticks = 0; m_stall = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in('0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle(1);

        // Single XOR op, register operand
        out_ready = 1'b1;
        o = '0;
        o.rs1 = 32'hAAAA_AAAA; o.rs2 = 32'h5555_5555; o.alu_op = 4'd4;
        o.pc = 32'h100; o.rd = 5'd3; o.reg_write = 1'b1;
        offer(o, -1);
        chk("xor_op_b", op_b, 32'h5555_5555);
        idle(2);

        // Immediate select
        o = '0;
        o.rs2 = 32'h1234; o.imm = 32'hFFFF_FFF0; o.alu_src = 1'b1; o.pc = 32'h104;
        offer(o, -1);
        chk("imm_op_b", op_b, 32'hFFFF_FFF0);
        idle(2);

        // Back-pressure: three ops offered while EX stalls
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = rand_op();
            o.pc = 32'(i * 4);
            offer(o, (i == 2) ? 3 : -1);
        end
        idle(4);

        // Streaming: one op per cycle
        out_ready = 1'b1;
        t0 = n_ticks;
        for (int i = 0; i < 100; i++) offer(rand_op(), -1);
        chk("stream_cycles", 32'(n_ticks - t0), 32'd100);
        idle(2);

        // Flush while full with a new op offered in the same cycle
        out_ready = 1'b0;
        offer(rand_op(), -1);
        offer(rand_op(), -1);
        set_in(rand_op());
        in_valid = 1'b1;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Random mix of handshakes and flushes
        for (int i = 0; i < 400; i++) begin
            set_in(rand_op());
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick(acc);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Asynchronous reset while full, away from any clock edge
        out_ready = 1'b0;
        offer(rand_op(), -1);
        offer(rand_op(), -1);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_stall = '0;
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(rand_op(), -1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
